// File: rtl/dxm_interrupt_low_pkg.sv
// Shared helpers for the dxm_interrupt_low status/mask controller.
// Holds the sticky-bit next-state rule used by each per-source cell.
package dxm_interrupt_low_pkg;

    localparam int DXM_INT_MAX_WIDTH = 32;

    // Set beats clear so an event arriving alongside a W1C is never lost.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/dxm_interrupt_low_bit.sv
// One sticky interrupt status bit with set-over-clear priority and its
// masked request contribution.
module dxm_int_bit
    import dxm_interrupt_low_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic evt_1p,
    input  logic clr_1p,
    input  logic mask_bit,
    output logic status_bit,
    output logic req_bit
);

    always_ff @(posedge clk) begin
        if (rst) status_bit <= 1'b0;
        else     status_bit <= sticky_next(status_bit, evt_1p, clr_1p);
    end

    assign req_bit = status_bit & ~mask_bit;

endmodule

// File: rtl/dxm_interrupt_low.sv
// Interrupt status/mask controller: WIDTH sticky sources, W1C clear, one int_req.
// Define DXM_INT_REQ_REG_EN to register int_req (one extra cycle of latency).
module dxm_interrupt_low
    import dxm_interrupt_low_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] r_din,
    input  logic             clr_status_1p,
    input  logic [WIDTH-1:0] events_1p,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] status,
    output logic             int_req
);

    logic [WIDTH-1:0] req_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dxm_int_bit u_bit (
            .clk        (clk),
            .rst        (rst),
            .evt_1p     (events_1p[i]),
            .clr_1p     (clr_status_1p & r_din[i]),
            .mask_bit   (mask[i]),
            .status_bit (status[i]),
            .req_bit    (req_vec[i])
        );
    end

`ifdef DXM_INT_REQ_REG_EN
    always_ff @(posedge clk) begin
        if (rst) int_req <= 1'b0;
        else     int_req <= |req_vec;
    end
`else
    // Combinational so an unmask of an already-pending source is seen at once.
    assign int_req = |req_vec;
`endif

endmodule

// File: tb/tb_dxm_interrupt_low.sv
// Scoreboard bench for dxm_interrupt_low at WIDTH=4 and WIDTH=11.
module tb_dxm_interrupt_low;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [10:0] ev, din, msk;
    logic [3:0]  st4;
    logic        ir4;
    logic [10:0] st11;
    logic        ir11;

    always #5 clk = ~clk;

    dxm_interrupt_low #(4) u_dut4 (
        .clk(clk), .rst(rst), .r_din(din[3:0]), .clr_status_1p(clr),
        .events_1p(ev[3:0]), .mask(msk[3:0]), .status(st4), .int_req(ir4)
    );

    dxm_interrupt_low #(11) u_dut11 (
        .clk(clk), .rst(rst), .r_din(din), .clr_status_1p(clr),
        .events_1p(ev), .mask(msk), .status(st11), .int_req(ir11)
    );

    typedef struct {
        logic [10:0] st11;
        logic        i11;
        logic [3:0]  st4;
        logic        i4;
    } exp_t;

    exp_t        q[$];
    logic [10:0] m_st = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    bit          done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sources are independent sticky bits; set wins over W1C.
    task automatic cyc(input logic r, input logic [10:0] e, input logic c,
                       input logic [10:0] d, input logic [10:0] m);
        exp_t        x;
        logic [10:0] nxt, clr_bits;
        @(negedge clk);
        rst = r; ev = e; clr = c; din = d; msk = m;
        clr_bits = c ? d : 11'h0;
        nxt = r ? 11'h0 : ((m_st & ~clr_bits) | e);
        x.st11 = nxt;
        x.st4  = nxt[3:0];
`ifdef DXM_INT_REQ_REG_EN
        x.i11 = r ? 1'b0 : ((m_st & ~m) != 0);
        x.i4  = r ? 1'b0 : ((m_st[3:0] & ~m[3:0]) != 0);
`else
        x.i11 = (nxt & ~m) != 0;
        x.i4  = (nxt[3:0] & ~m[3:0]) != 0;
`endif
        m_st = nxt;
        q.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle; compare just after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("status4",  {28'h0, st4},  {28'h0, x.st4});
                check("int_req4", {31'h0, ir4},  {31'h0, x.i4});
                check("status11", {21'h0, st11}, {21'h0, x.st11});
                check("int_req11", {31'h0, ir11}, {31'h0, x.i11});
            end
        end
    end

    initial begin
        logic [10:0] e, d, m;
        rst = 1'b1; clr = 1'b0; ev = '0; din = '0; msk = '0;

        // Reset dominates events
        cyc(1, 11'h00F, 0, 11'h000, 11'h000);
        cyc(1, 11'h00F, 0, 11'h000, 11'h000);
        cyc(0, 11'h000, 0, 11'h000, 11'h000);

        // Capture and stickiness
        cyc(0, 11'b0010, 0, 11'h000, 11'h000);
        repeat (10) cyc(0, 11'h000, 0, 11'h000, 11'h000);

        // Masked event, then unmask
        cyc(0, 11'h000, 1, 11'h7FF, 11'h7FF);
        cyc(0, 11'b0001, 0, 11'h000, 11'h7FF);
        cyc(0, 11'h000, 0, 11'h000, 11'h7FF);
        cyc(0, 11'h000, 0, 11'h000, 11'h7FE);
        cyc(0, 11'h000, 0, 11'h000, 11'h7FE);

        // Selective clear; write-zero and r_din without strobe have no effect
        cyc(0, 11'h000, 1, 11'h7FF, 11'h000);
        cyc(0, 11'b1011, 0, 11'h000, 11'h000);
        cyc(0, 11'h000, 1, 11'b0010, 11'h000);
        cyc(0, 11'h000, 1, 11'b0100, 11'h000);
        cyc(0, 11'h000, 0, 11'h7FF, 11'h000);

        // Set/clear collision
        cyc(0, 11'h000, 1, 11'h7FF, 11'h000);
        cyc(0, 11'b0001, 0, 11'h000, 11'h000);
        cyc(0, 11'b0001, 1, 11'b0001, 11'h000);
        cyc(0, 11'h000, 0, 11'h000, 11'h000);

        // All sources, then full clear
        cyc(0, 11'h7FF, 0, 11'h000, 11'h000);
        cyc(0, 11'h000, 1, 11'h7FF, 11'h000);
        cyc(0, 11'h000, 0, 11'h000, 11'h000);

        // Held event stays set through a clear
        repeat (3) cyc(0, 11'h100, 1, 11'h100, 11'h000);

        for (int k = 0; k < 400; k++) begin
            e = 11'($urandom) & 11'($urandom) & 11'($urandom);
            d = 11'($urandom);
            m = 11'($urandom);
            cyc(($urandom_range(0, 40) == 0), e, ($urandom_range(0, 2) == 0), d, m);
        end

        cyc(0, 11'h000, 0, 11'h000, 11'h000);
        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d pending expected entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
